iob_halfdup_ctrl: RTL
=====================

// Module: iob_halfdup_ctrl
// PURPOSE
//  Half-duplex serial controller for one tristate pad driven through an iob instance.
//  - Arbitrates one write requester and one read requester for the shared pin.
//  - Serialises or deserialises DATA_W-bit words at CLK_DIV clocks per bit.
//  - Inserts high-Z turnaround cycles on every drive-direction change.
// PARAMETERS
//  DATA_W       8  word width in bits, sent and received MSB first
//  CLK_DIV      4  clocks per bit period, >=2
//  SAMPLE_PT    2  clock index within a bit period at which RX samples pad_o, 0..CLK_DIV-1
//  TURN_CYCLES  2  released (pad_t=0) cycles inserted before every direction change, >=1
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  wr_valid   in   1       write word available
//  wr_ready   out  1       write word accepted when wr_valid && wr_ready
//  wr_data    in   DATA_W  word to transmit
//  rd_req     in   1       level request for one read word
//  rd_ack     out  1       1-cycle pulse: read request granted
//  rd_valid   out  1       1-cycle pulse: rd_data valid
//  rd_data    out  DATA_W  received word, held until the next rd_valid
//  rd_perr    out  1       parity error, qualified by rd_valid
//  busy       out  1       state != IDLE
//  pad_i      out  1       to iob.i, the value driven onto the pad
//  pad_t      out  1       to iob.t: 1=drive pad, 0=high-Z
//  pad_o      in   1       from iob.o, the pad value; asynchronous to clk, double-flopped internally
// BEHAVIOUR
//  - Reset (async, immediate): pad_t=0, pad_i=0, wr_ready=0, rd_ack=0, rd_valid=0, rd_data=0.
//    Also at reset: rd_perr=0, busy=0, state=IDLE, last_dir=RX, last_grant=RD (so first priority is write).
//  - A reset asserted mid-TX releases the pad on the same edge; the partial word is discarded.
//  - States: IDLE -> TURN (if new dir != last_dir) or straight to TX/RX; TURN -> TX/RX; TX/RX -> IDLE.
//  - Arbitration is evaluated in IDLE only, round-robin on last_grant when wr_valid and rd_req are both high.
//    A single pending request always wins.
//  - wr_ready = (state==IDLE) && grant_wr, combinational from registered state.
//    wr_data is captured on the handshake cycle.
//  - rd_ack pulses on the read grant cycle. The requester drops rd_req after rd_ack.
//  - TURN: pad_t=0 for exactly TURN_CYCLES cycles, then last_dir is updated.
//  - TX: pad_t=1 and pad_i=current bit, each bit held CLK_DIV cycles.
//    Word time is DATA_W*CLK_DIV cycles (+CLK_DIV with parity).
//  - A write accepted at cycle N drives from N+1 (+TURN_CYCLES if turning); pad_t falls on exit to IDLE.
//  - RX: pad_t=0 throughout; the synchronised pad_o is sampled at index SAMPLE_PT of each bit period.
//    rd_valid pulses on the cycle after the final bit period, with the full word in rd_data.
//  - Back-to-back same-direction words take one IDLE cycle between words, with no turnaround.
//    For TX, pad_t drops to 0 for that cycle.
//  - Bit counter is $clog2(DATA_W+1) bits; the divider counter wraps CLK_DIV-1 -> 0.
//    Neither counter runs in IDLE or TURN.
//  - Simultaneous rd_req deassert and grant: the grant stands and the read completes.
// CONFIGURATION
//  IOB_HALFDUP_PARITY_EN defined:
//  - TX appends one even-parity bit after the LSB.
//  - RX samples one extra bit; rd_perr=1 with rd_valid when parity mismatches.
//  Undefined:
//  - No parity bit is sent or sampled.
//  - rd_perr is tied 0.
// STRUCTURE
//  - iob_halfdup_pkg: state_t enum {IDLE,TURN,TX,RX}, dir_t enum {DIR_RX,DIR_TX}, and a bits-per-frame function.
//  - Sub-module iob_bit_timer: CLK_DIV divider plus bit counter.
//    Outputs: bit_tick, sample_tick, last_bit. Input: start. Reused by TX and RX.
//  - The iob itself is instantiated by the parent, not inside this block.
// TESTING (DATA_W=8, CLK_DIV=4, SAMPLE_PT=2, TURN_CYCLES=2)
//  1. After reset, write 0xA5 accepted at cycle 0 -> pad_t=0 at cycles 1-2, then pad_t=1 at cycles 3-34.
//     pad_i carries 1,0,1,0,0,1,0,1 with 4 cycles each; busy falls at cycle 35.
//  2. Writes 0x3C then 0xFF back-to-back -> no TURN; one pad_t=0 IDLE cycle between two 32-cycle frames.
//  3. Read after write, with the bench driving 0x5A on the pad after turnaround -> rd_ack at accept.
//     pad_t=0 throughout; rd_valid=1 with rd_data=0x5A at accept+2+32+1.
//  4. wr_valid and rd_req high together in IDLE with last_grant=WR -> read is granted (rd_ack=1, wr_ready=0).
//     The write is served next.
//  5. rst_n low during TX bit 3 -> pad_t=0 immediately, all outputs at reset values.
//     The next write after reset incurs TURN.
//  6. With IOB_HALFDUP_PARITY_EN, write 0x07 -> 9th bit=1.
//     RX of 0x07 with parity bit 0 -> rd_perr=1 alongside rd_valid.

Source files
------------

// File: rtl/iob_halfdup_pkg.sv
// Shared types and frame-size helper for the half-duplex pad controller.
// IOB_HALFDUP_PARITY_EN adds one even-parity bit to every frame.
package iob_halfdup_pkg;

  typedef enum logic [1:0] {IDLE, TURN, TX, RX} state_t;
  typedef enum logic {DIR_RX, DIR_TX} dir_t;
  typedef enum logic {GNT_RD, GNT_WR} grant_t;

`ifdef IOB_HALFDUP_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  // Number of bit periods on the wire for one data word.
  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + int'(ParityEn);
  endfunction

endpackage

// File: rtl/iob_bit_timer.sv
// Bit-period divider and bit counter shared by the TX and RX paths.
// Counters are cleared by start_i and only advance while en_i is high.
module iob_bit_timer #(
  parameter int unsigned ClkDiv   = 4,
  parameter int unsigned SamplePt = 2,
  parameter int unsigned NumBits  = 8,
  parameter int unsigned CntW     = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic en_i,
  output logic bit_tick_o,
  output logic sample_tick_o,
  output logic last_bit_o
);

  localparam int unsigned DivW = $clog2(ClkDiv);
  localparam logic [DivW-1:0] DivMax = DivW'(ClkDiv - 1);
  localparam logic [DivW-1:0] DivSmp = DivW'(SamplePt);
  localparam logic [CntW-1:0] BitMax = CntW'(NumBits - 1);

  logic [DivW-1:0] div_q;
  logic [CntW-1:0] bit_q;

  assign bit_tick_o    = en_i && (div_q == DivMax);
  assign sample_tick_o = en_i && (div_q == DivSmp);
  assign last_bit_o    = (bit_q == BitMax);

  // Divider wraps ClkDiv-1 -> 0; bit counter returns to 0 after the last bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      bit_q <= '0;
    end else if (start_i) begin
      div_q <= '0;
      bit_q <= '0;
    end else if (en_i) begin
      if (div_q == DivMax) begin
        div_q <= '0;
        bit_q <= last_bit_o ? '0 : bit_q + CntW'(1);
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

endmodule

// File: rtl/iob_halfdup_ctrl.sv
// Half-duplex serial controller for one tristate pad (iob lives in the parent).
// Round-robin arbitration between one writer and one reader, MSB-first framing,
// high-Z turnaround on every direction change.
// IOB_HALFDUP_PARITY_EN: append/check an even-parity bit; otherwise rd_perr is 0.
module iob_halfdup_ctrl
  import iob_halfdup_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned SAMPLE_PT   = 2,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_perr,
  output logic              busy,
  output logic              pad_i,
  output logic              pad_t,
  input  logic              pad_o
);

  localparam int unsigned FrameBits = frame_bits(DATA_W);
  localparam int unsigned CntW      = $clog2(DATA_W + 1);
  localparam int unsigned TurnW     = $clog2(TURN_CYCLES + 1);
  localparam logic [TurnW-1:0] TurnMax = TurnW'(TURN_CYCLES - 1);

  state_t             state_q;
  dir_t               last_dir_q, tgt_dir_q;
  grant_t             last_grant_q;
  logic [TurnW-1:0]   turn_cnt_q;
  logic [FrameBits-1:0] tx_sh_q, rx_sh_q;
  logic               pad_t_q, pad_i_q;
  logic               rd_valid_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               sync1_q, sync2_q;

  logic               grant_wr, grant_rd;
  dir_t               req_dir, enter_dir;
  logic               turn_done, enter_data;
  logic               bit_tick, sample_tick, last_bit, frame_done;
  logic [FrameBits-1:0] tx_load, tx_src, rx_next;
  logic [DATA_W-1:0]  rx_word;

  // Round-robin only matters when both requesters are present.
  assign grant_wr  = wr_valid && (!rd_req || (last_grant_q == GNT_RD));
  assign grant_rd  = rd_req && (!wr_valid || (last_grant_q == GNT_WR));
  assign wr_ready  = (state_q == IDLE) && grant_wr;
  assign rd_ack    = (state_q == IDLE) && grant_rd;
  assign busy      = (state_q != IDLE);
  assign req_dir   = grant_wr ? DIR_TX : DIR_RX;
  assign turn_done = (state_q == TURN) && (turn_cnt_q == TurnMax);

  // Data phase starts straight from IDLE when no turnaround is needed.
  assign enter_data = ((state_q == IDLE) && (grant_wr || grant_rd) && (req_dir == last_dir_q))
                      || turn_done;
  assign enter_dir  = (state_q == IDLE) ? req_dir : tgt_dir_q;
  assign frame_done = bit_tick && last_bit;

`ifdef IOB_HALFDUP_PARITY_EN
  logic rd_perr_q;
  assign tx_load = {wr_data, ^wr_data};
  assign rx_word = rx_next[FrameBits-1:1];
  assign rd_perr = rd_perr_q;
`else
  assign tx_load = wr_data;
  assign rx_word = rx_next;
  assign rd_perr = 1'b0;
`endif

  // Word being loaded this cycle when going straight from IDLE to TX.
  assign tx_src  = (state_q == IDLE) ? tx_load : tx_sh_q;
  // Include a sample taken on the final tick so SAMPLE_PT=CLK_DIV-1 still works.
  assign rx_next = sample_tick ? {rx_sh_q[FrameBits-2:0], sync2_q} : rx_sh_q;

  assign pad_t    = pad_t_q;
  assign pad_i    = pad_i_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  iob_bit_timer #(
    .ClkDiv   (CLK_DIV),
    .SamplePt (SAMPLE_PT),
    .NumBits  (FrameBits),
    .CntW     (CntW)
  ) u_bit_timer (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (enter_data),
    .en_i          ((state_q == TX) || (state_q == RX)),
    .bit_tick_o    (bit_tick),
    .sample_tick_o (sample_tick),
    .last_bit_o    (last_bit)
  );

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_o;
      sync2_q <= sync1_q;
    end
  end

  // Main FSM with registered pad and read-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_dir_q   <= DIR_RX;
      tgt_dir_q    <= DIR_RX;
      last_grant_q <= GNT_RD;
      turn_cnt_q   <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      pad_t_q      <= 1'b0;
      pad_i_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
`ifdef IOB_HALFDUP_PARITY_EN
      rd_perr_q    <= 1'b0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            last_grant_q <= grant_wr ? GNT_WR : GNT_RD;
            tgt_dir_q    <= req_dir;
            if (grant_wr) tx_sh_q <= tx_load;
            if (req_dir != last_dir_q) begin
              state_q    <= TURN;
              turn_cnt_q <= '0;
            end
          end
        end
        TURN: begin
          if (turn_done) last_dir_q <= tgt_dir_q;
          else           turn_cnt_q <= turn_cnt_q + TurnW'(1);
        end
        TX: begin
          if (bit_tick) begin
            if (last_bit) begin
              state_q <= IDLE;
              pad_t_q <= 1'b0;
              pad_i_q <= 1'b0;
            end else begin
              pad_i_q <= tx_sh_q[FrameBits-1];
              tx_sh_q <= tx_sh_q << 1;
            end
          end
        end
        RX: begin
          rx_sh_q <= rx_next;
          if (frame_done) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b1;
            rd_data_q  <= rx_word;
`ifdef IOB_HALFDUP_PARITY_EN
            rd_perr_q  <= ^rx_next;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
      // Entering the data phase overrides the IDLE/TURN updates above.
      if (enter_data) begin
        state_q <= (enter_dir == DIR_TX) ? TX : RX;
        if (enter_dir == DIR_TX) begin
          pad_t_q <= 1'b1;
          pad_i_q <= tx_src[FrameBits-1];
          tx_sh_q <= tx_src << 1;
        end
      end
    end
  end

endmodule
